// File: rtl/json_parse_arbiter.sv
// ---------------------------------------------------------------------------
// json_parse_arbiter
//
// Shares one single-object JSON pair-counting parser between two byte-stream
// sources. A source is granted per object (round-robin between s0 and s1) and
// keeps the grant from its opening '{' until its closing '}'. Characters are
// forwarded to the parser one per clock. Over-long objects are force-closed
// by injecting a '}'. The parser's pair count is captured and returned tagged
// with the source id and error flags.
//
// Parameters
//   FILL_CHAR    character driven to the parser when nothing is forwarded
//   MAX_OBJ_LEN  chars forwarded after '{' before a forced close (2..255)
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   s0_char/valid/ready   source 0 byte stream (consumed on valid & ready)
//   s1_char/valid/ready   source 1 byte stream (consumed on valid & ready)
//   p_char                character to the parser, sampled every rising edge
//   p_cur_num             parser pair count, valid the cycle after '}'
//   res_valid             single-cycle pulse, result fields updated
//   res_src/num           source id and captured pair count
//   res_gap               a valid-low bubble was forwarded inside the object
//   res_aborted           object was force-closed by the length limit
//   stat0/stat1           per-source count of clean, non-empty objects
//
// Optional feature (macro JSON_ARB_STATS_EN)
//   Defined:     stat0/stat1 count captures with no gap, no abort and a
//                non-zero pair count, saturating at 8'hFF.
//   Not defined: stat0/stat1 are tied to zero.
// ---------------------------------------------------------------------------
module json_parse_arbiter #(
  parameter logic [7:0] FILL_CHAR   = 8'h20,
  parameter int         MAX_OBJ_LEN = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] s0_char,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [7:0] s1_char,
  input  logic       s1_valid,
  output logic       s1_ready,
  output logic [7:0] p_char,
  input  logic [7:0] p_cur_num,
  output logic       res_valid,
  output logic       res_src,
  output logic [7:0] res_num,
  output logic       res_gap,
  output logic       res_aborted,
  output logic [7:0] stat0,
  output logic [7:0] stat1
);

  localparam int              LEN_W   = $clog2(MAX_OBJ_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_OBJ_LEN);
  localparam logic [7:0]      OPEN_BRACE  = 8'h7B;
  localparam logic [7:0]      CLOSE_BRACE = 8'h7D;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    CLOSE,
    CAPTURE
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic             r_ptr;
  logic             r_grant;
  logic             r_inObj;
  logic             r_gap;
  logic             r_abort;
  logic [LEN_W-1:0] r_len;

  logic             w_ptrNext;
  logic             w_grantNext;
  logic             w_inObjNext;
  logic             w_gapNext;
  logic             w_abortNext;
  logic [LEN_W-1:0] w_lenNext;
  logic [LEN_W-1:0] w_lenInc;
  logic             w_selValid;
  logic [7:0]       w_selChar;
  logic             w_s0Ready;
  logic             w_s1Ready;
  logic [7:0]       w_pChar;
  logic             w_capture;

  logic             r_resValid;
  logic             r_resSrc;
  logic [7:0]       r_resNum;
  logic             r_resGap;
  logic             r_resAborted;

  // The granted source's stream, muxed once so the FSM only looks at one.
  assign w_selValid = r_grant ? s1_valid : s0_valid;
  assign w_selChar  = r_grant ? s1_char  : s0_char;

  // Length as it will be after this cycle; the limit check uses it so the
  // forced close follows directly after the MAX_OBJ_LEN-th character.
  assign w_lenInc = r_len + 1'b1;

  // State and per-object bookkeeping registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_grant <= 1'b0;
      r_inObj <= 1'b0;
      r_gap   <= 1'b0;
      r_abort <= 1'b0;
      r_len   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_ptr   <= w_ptrNext;
      r_grant <= w_grantNext;
      r_inObj <= w_inObjNext;
      r_gap   <= w_gapNext;
      r_abort <= w_abortNext;
      r_len   <= w_lenNext;
    end
  end

  // Next-state logic and the combinational handshake / parser character.
  // Ready is granted irrespective of valid so a missing character shows up
  // as a fill bubble instead of stalling the parser, which cannot stall.
  always_comb begin
    w_stateNext = r_state;
    w_ptrNext   = r_ptr;
    w_grantNext = r_grant;
    w_inObjNext = r_inObj;
    w_gapNext   = r_gap;
    w_abortNext = r_abort;
    w_lenNext   = r_len;
    w_s0Ready   = 1'b0;
    w_s1Ready   = 1'b0;
    w_pChar     = FILL_CHAR;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (s0_valid || s1_valid) begin
          // Pointer-preferred source if it is valid, otherwise the other.
          w_grantNext = r_ptr ? s1_valid : ~s0_valid;
          w_stateNext = BUSY;
        end
      end
      BUSY: begin
        w_s0Ready = ~r_grant;
        w_s1Ready = r_grant;
        if (w_selValid) begin
          w_pChar = w_selChar;
        end
        if (!r_inObj) begin
          if (!w_selValid) begin
            w_stateNext = IDLE;
            w_ptrNext   = ~r_ptr;
          end else if (w_selChar == OPEN_BRACE) begin
            w_inObjNext = 1'b1;
            w_lenNext   = '0;
          end
        end else begin
          w_lenNext = w_lenInc;
          if (!w_selValid) begin
            w_gapNext = 1'b1;
          end
          if (w_selValid && (w_selChar == CLOSE_BRACE)) begin
            w_stateNext = CAPTURE;
          end else if (w_lenInc == LEN_MAX) begin
            w_stateNext = CLOSE;
          end
        end
      end
      CLOSE: begin
        w_pChar     = CLOSE_BRACE;
        w_abortNext = 1'b1;
        w_stateNext = CAPTURE;
      end
      CAPTURE: begin
        w_capture   = 1'b1;
        w_ptrNext   = ~r_grant;
        w_inObjNext = 1'b0;
        w_gapNext   = 1'b0;
        w_abortNext = 1'b0;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Result registers: updated only on capture, res_valid pulses for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resValid   <= 1'b0;
      r_resSrc     <= 1'b0;
      r_resNum     <= 8'h00;
      r_resGap     <= 1'b0;
      r_resAborted <= 1'b0;
    end else begin
      r_resValid <= w_capture;
      if (w_capture) begin
        r_resSrc     <= r_grant;
        r_resNum     <= p_cur_num;
        r_resGap     <= r_gap;
        r_resAborted <= r_abort;
      end
    end
  end

  assign s0_ready    = w_s0Ready;
  assign s1_ready    = w_s1Ready;
  assign p_char      = w_pChar;
  assign res_valid   = r_resValid;
  assign res_src     = r_resSrc;
  assign res_num     = r_resNum;
  assign res_gap     = r_resGap;
  assign res_aborted = r_resAborted;

`ifdef JSON_ARB_STATS_EN
  logic [7:0] r_stat0;
  logic [7:0] r_stat1;
  logic       w_statHit;

  // Only clean objects with at least one pair are counted.
  assign w_statHit = w_capture && !r_gap && !r_abort && (p_cur_num != 8'h00);

  // Saturating per-source completed-object counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat0 <= 8'h00;
      r_stat1 <= 8'h00;
    end else if (w_statHit) begin
      if (!r_grant && (r_stat0 != 8'hFF)) begin
        r_stat0 <= r_stat0 + 8'd1;
      end
      if (r_grant && (r_stat1 != 8'hFF)) begin
        r_stat1 <= r_stat1 + 8'd1;
      end
    end
  end

  assign stat0 = r_stat0;
  assign stat1 = r_stat1;
`else
  assign stat0 = 8'h00;
  assign stat1 = 8'h00;
`endif

endmodule

// File: tb/tb_json_parse_arbiter.sv
// ---------------------------------------------------------------------------
// tb_json_parse_arbiter
//
// Bench for json_parse_arbiter. Two queue-fed source drivers, a small
// behavioural pair-counting parser on p_char/p_cur_num, and a scoreboard of
// expected results pushed when a stream is loaded and popped on res_valid.
// The DUT is built with a 16-character object limit.
// ---------------------------------------------------------------------------
module tb_json_parse_arbiter;

  localparam int MAX_LEN = 16;
`ifdef JSON_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef struct packed {
    logic       src;
    logic [7:0] num;
    logic       gap;
    logic       aborted;
  } result_t;

  logic       clk;
  logic       reset_n;
  logic [7:0] s0_char;
  logic       s0_valid;
  logic       s0_ready;
  logic [7:0] s1_char;
  logic       s1_valid;
  logic       s1_ready;
  logic [7:0] p_char;
  logic [7:0] p_cur_num;
  logic       res_valid;
  logic       res_src;
  logic [7:0] res_num;
  logic       res_gap;
  logic       res_aborted;
  logic [7:0] stat0;
  logic [7:0] stat1;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         pop0 = 0;
  int         pop1 = 0;
  int         close0Cyc = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  result_t    sb[$];
  logic [7:0] expStat0 = 8'h00;
  logic [7:0] expStat1 = 8'h00;

  json_parse_arbiter #(
    .FILL_CHAR  (8'h20),
    .MAX_OBJ_LEN(MAX_LEN)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s0_char    (s0_char),
    .s0_valid   (s0_valid),
    .s0_ready   (s0_ready),
    .s1_char    (s1_char),
    .s1_valid   (s1_valid),
    .s1_ready   (s1_ready),
    .p_char     (p_char),
    .p_cur_num  (p_cur_num),
    .res_valid  (res_valid),
    .res_src    (res_src),
    .res_num    (res_num),
    .res_gap    (res_gap),
    .res_aborted(res_aborted),
    .stat0      (stat0),
    .stat1      (stat1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter, stable when sampled at the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural parser: counts ':' inside one object, reports 0 if a space
  // or nested '{' appears, and publishes the count on the edge seeing '}'.
  logic       pIn;
  logic       pBad;
  logic [7:0] pPairs;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pIn       <= 1'b0;
      pBad      <= 1'b0;
      pPairs    <= 8'h00;
      p_cur_num <= 8'h00;
    end else if (!pIn) begin
      if (p_char == 8'h7B) begin
        pIn    <= 1'b1;
        pBad   <= 1'b0;
        pPairs <= 8'h00;
      end
    end else begin
      case (p_char)
        8'h7D: begin
          pIn       <= 1'b0;
          p_cur_num <= pBad ? 8'h00 : pPairs;
        end
        8'h3A:        pPairs <= pPairs + 8'd1;
        8'h20, 8'h7B: pBad   <= 1'b1;
        default: ;
      endcase
    end
  end

  // Source 0 driver: bit 8 of a queue entry marks a one-cycle valid bubble.
  initial begin
    s0_valid = 1'b0;
    s0_char  = 8'h20;
    forever begin
      @(negedge clk);
      if (q0.size() > 0 && !q0[0][8]) begin
        s0_valid = 1'b1;
        s0_char  = q0[0][7:0];
      end else begin
        s0_valid = 1'b0;
        s0_char  = 8'h20;
      end
      #1;
      if (q0.size() > 0 && s0_ready) begin
        if (!q0[0][8] && q0[0][7:0] == 8'h7D) close0Cyc = cyc;
        void'(q0.pop_front());
        pop0++;
      end
    end
  end

  // Source 1 driver.
  initial begin
    s1_valid = 1'b0;
    s1_char  = 8'h20;
    forever begin
      @(negedge clk);
      if (q1.size() > 0 && !q1[0][8]) begin
        s1_valid = 1'b1;
        s1_char  = q1[0][7:0];
      end else begin
        s1_valid = 1'b0;
        s1_char  = 8'h20;
      end
      #1;
      if (q1.size() > 0 && s1_ready) begin
        void'(q1.pop_front());
        pop1++;
      end
    end
  end

  task automatic pushStr(input bit src, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (src) q1.push_back({1'b0, s[i]});
      else     q0.push_back({1'b0, s[i]});
    end
  endtask

  task automatic pushExp(input bit src, input int num, input bit gap, input bit ab);
    result_t r;
    r.src     = src;
    r.num     = 8'(num);
    r.gap     = gap;
    r.aborted = ab;
    sb.push_back(r);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    sb.delete();
    expStat0 = 8'h00;
    expStat1 = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    vectors += 9;
    if (s0_ready !== 1'b0)    begin miscompares++; $display("[TB] FAIL rst_s0_ready got %b want 0", s0_ready); end
    if (s1_ready !== 1'b0)    begin miscompares++; $display("[TB] FAIL rst_s1_ready got %b want 0", s1_ready); end
    if (p_char !== 8'h20)     begin miscompares++; $display("[TB] FAIL rst_p_char got %h want 20", p_char); end
    if (res_valid !== 1'b0)   begin miscompares++; $display("[TB] FAIL rst_res_valid got %b want 0", res_valid); end
    if (res_src !== 1'b0)     begin miscompares++; $display("[TB] FAIL rst_res_src got %b want 0", res_src); end
    if (res_num !== 8'h00)    begin miscompares++; $display("[TB] FAIL rst_res_num got %h want 00", res_num); end
    if ({res_gap, res_aborted} !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_flags got %b want 00", {res_gap, res_aborted}); end
    if (stat0 !== 8'h00)      begin miscompares++; $display("[TB] FAIL rst_stat0 got %h want 00", stat0); end
    if (stat1 !== 8'h00)      begin miscompares++; $display("[TB] FAIL rst_stat1 got %h want 00", stat1); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    result_t exp;
    int resCyc = -1;
    pushStr(0, "{\"a\":\"1\",\"b\":\"2\"}");
    pushExp(0, 2, 0, 0);
    for (int c = 0; c < 200 && (sb.size() > 0 || q0.size() > 0); c++) begin
      @(negedge clk); #2;
      if (res_valid) begin
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("[TB] FAIL single_unexpected res_valid=1 want none"); end
        else begin
          exp = sb.pop_front();
          if (resCyc < 0) resCyc = cyc;
          if ({res_src, res_num, res_gap, res_aborted} !== exp) begin
            miscompares++;
            $display("[TB] FAIL single_result got src=%0d num=%0d gap=%0d ab=%0d want src=%0d num=%0d gap=%0d ab=%0d",
                     res_src, res_num, res_gap, res_aborted, exp.src, exp.num, exp.gap, exp.aborted);
          end
          if (!exp.gap && !exp.aborted && exp.num != 0 && expStat0 != 8'hFF) expStat0++;
        end
      end
    end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("[TB] FAIL single_timeout pending=%0d want 0", sb.size()); end
    vectors++;
    if (resCyc != close0Cyc + 2) begin miscompares++; $display("[TB] FAIL single_latency got %0d want %0d", resCyc - close0Cyc, 2); end
    @(negedge clk); #2;
    vectors += 3;
    if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_pulse got res_valid=%b want 0", res_valid); end
    if (res_num !== 8'd2)   begin miscompares++; $display("[TB] FAIL single_hold got res_num=%0d want 2", res_num); end
    if (stat0 !== (STATS_ON ? expStat0 : 8'h00)) begin miscompares++; $display("[TB] FAIL single_stat0 got %0d want %0d", stat0, STATS_ON ? expStat0 : 8'h00); end
  endtask

  task automatic test_round_robin();
    result_t exp;
    bit overlap = 0;
    pulseReset();
    pushStr(0, "{\"k\":\"v\"}{\"k\":\"v\"}");
    pushStr(1, "{\"k\":\"v\"}{\"k\":\"v\"}");
    pushExp(0, 1, 0, 0);
    pushExp(1, 1, 0, 0);
    pushExp(0, 1, 0, 0);
    pushExp(1, 1, 0, 0);
    for (int c = 0; c < 300 && (sb.size() > 0 || q0.size() > 0 || q1.size() > 0); c++) begin
      @(negedge clk); #2;
      if (s0_ready && s1_ready) overlap = 1;
      if (res_valid) begin
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("[TB] FAIL rr_unexpected res_valid=1 want none"); end
        else begin
          exp = sb.pop_front();
          if ({res_src, res_num, res_gap, res_aborted} !== exp) begin
            miscompares++;
            $display("[TB] FAIL rr_result got src=%0d num=%0d gap=%0d ab=%0d want src=%0d num=%0d gap=%0d ab=%0d",
                     res_src, res_num, res_gap, res_aborted, exp.src, exp.num, exp.gap, exp.aborted);
          end
          if (!exp.gap && !exp.aborted && exp.num != 0) begin
            if (exp.src && expStat1 != 8'hFF) expStat1++;
            if (!exp.src && expStat0 != 8'hFF) expStat0++;
          end
        end
      end
    end
    repeat (3) @(negedge clk);
    vectors += 4;
    if (sb.size() != 0) begin miscompares++; $display("[TB] FAIL rr_timeout pending=%0d want 0", sb.size()); end
    if (overlap)        begin miscompares++; $display("[TB] FAIL rr_ready_overlap got 1 want 0"); end
    if (stat0 !== (STATS_ON ? expStat0 : 8'h00)) begin miscompares++; $display("[TB] FAIL rr_stat0 got %0d want %0d", stat0, STATS_ON ? expStat0 : 8'h00); end
    if (stat1 !== (STATS_ON ? expStat1 : 8'h00)) begin miscompares++; $display("[TB] FAIL rr_stat1 got %0d want %0d", stat1, STATS_ON ? expStat1 : 8'h00); end
  endtask

  task automatic test_gap();
    result_t exp;
    bit bubSeen = 0;
    logic [7:0] bubChar = 8'h00;
    pushStr(0, "{\"a\":");
    q0.push_back(9'h100);
    pushStr(0, "\"1\"}");
    pushExp(0, 0, 1, 0);
    for (int c = 0; c < 200 && (sb.size() > 0 || q0.size() > 0); c++) begin
      @(negedge clk); #2;
      if (!bubSeen && s0_ready && !s0_valid && pIn) begin
        bubSeen = 1;
        bubChar = p_char;
      end
      if (res_valid) begin
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("[TB] FAIL gap_unexpected res_valid=1 want none"); end
        else begin
          exp = sb.pop_front();
          if ({res_src, res_num, res_gap, res_aborted} !== exp) begin
            miscompares++;
            $display("[TB] FAIL gap_result got src=%0d num=%0d gap=%0d ab=%0d want src=%0d num=%0d gap=%0d ab=%0d",
                     res_src, res_num, res_gap, res_aborted, exp.src, exp.num, exp.gap, exp.aborted);
          end
        end
      end
    end
    repeat (2) @(negedge clk);
    vectors += 4;
    if (sb.size() != 0) begin miscompares++; $display("[TB] FAIL gap_timeout pending=%0d want 0", sb.size()); end
    if (!bubSeen)        begin miscompares++; $display("[TB] FAIL gap_bubble_seen got 0 want 1"); end
    if (bubChar !== 8'h20) begin miscompares++; $display("[TB] FAIL gap_fill_char got %h want 20", bubChar); end
    if (stat0 !== (STATS_ON ? expStat0 : 8'h00)) begin miscompares++; $display("[TB] FAIL gap_stat0 got %0d want %0d", stat0, STATS_ON ? expStat0 : 8'h00); end
  endtask

  task automatic test_abort();
    result_t exp;
    int base;
    int kCyc = 0;
    bit kSet = 0;
    bit closeChecked = 0;
    base = pop1;
    pushStr(1, "{\"abcdefghijklmnopqrs");
    pushExp(1, 0, 0, 1);
    for (int c = 0; c < 200 && (sb.size() > 0 || q1.size() > 0); c++) begin
      @(negedge clk); #2;
      if (kSet && !closeChecked && cyc == kCyc + 1) begin
        closeChecked = 1;
        vectors += 2;
        if (p_char !== 8'h7D)  begin miscompares++; $display("[TB] FAIL abort_inject got p_char=%h want 7d", p_char); end
        if (s1_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_ready got s1_ready=%b want 0", s1_ready); end
      end
      if (!kSet && pop1 == base + 1 + MAX_LEN) begin
        kSet = 1;
        kCyc = cyc;
      end
      if (res_valid) begin
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("[TB] FAIL abort_unexpected res_valid=1 want none"); end
        else begin
          exp = sb.pop_front();
          if ({res_src, res_num, res_gap, res_aborted} !== exp) begin
            miscompares++;
            $display("[TB] FAIL abort_result got src=%0d num=%0d gap=%0d ab=%0d want src=%0d num=%0d gap=%0d ab=%0d",
                     res_src, res_num, res_gap, res_aborted, exp.src, exp.num, exp.gap, exp.aborted);
          end
        end
      end
    end
    repeat (3) @(negedge clk);
    vectors += 3;
    if (sb.size() != 0) begin miscompares++; $display("[TB] FAIL abort_timeout pending=%0d want 0", sb.size()); end
    if (!closeChecked)  begin miscompares++; $display("[TB] FAIL abort_close_seen got 0 want 1"); end
    if (stat1 !== (STATS_ON ? expStat1 : 8'h00)) begin miscompares++; $display("[TB] FAIL abort_stat1 got %0d want %0d", stat1, STATS_ON ? expStat1 : 8'h00); end
  endtask

  task automatic test_empty_and_stats();
    result_t exp;
    pushStr(0, "{}");
    pushExp(0, 0, 0, 0);
    for (int n = 0; n < 300; n++) begin
      pushStr(0, "{\"k\":\"v\"}");
      pushExp(0, 1, 0, 0);
    end
    for (int c = 0; c < 5000 && (sb.size() > 0 || q0.size() > 0); c++) begin
      @(negedge clk); #2;
      if (res_valid) begin
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("[TB] FAIL stats_unexpected res_valid=1 want none"); end
        else begin
          exp = sb.pop_front();
          if ({res_src, res_num, res_gap, res_aborted} !== exp) begin
            miscompares++;
            $display("[TB] FAIL stats_result got src=%0d num=%0d gap=%0d ab=%0d want src=%0d num=%0d gap=%0d ab=%0d",
                     res_src, res_num, res_gap, res_aborted, exp.src, exp.num, exp.gap, exp.aborted);
          end
          if (!exp.gap && !exp.aborted && exp.num != 0 && expStat0 != 8'hFF) expStat0++;
        end
      end
    end
    repeat (2) @(negedge clk);
    vectors += 2;
    if (sb.size() != 0) begin miscompares++; $display("[TB] FAIL stats_timeout pending=%0d want 0", sb.size()); end
    if (stat0 !== (STATS_ON ? expStat0 : 8'h00)) begin miscompares++; $display("[TB] FAIL stats_sat got %0d want %0d", stat0, STATS_ON ? expStat0 : 8'h00); end
  endtask

  task automatic test_reset_mid();
    result_t exp;
    int base;
    base = pop0;
    pushStr(0, "{\"a\":\"1\",\"b\":\"2\"}");
    for (int c = 0; c < 50 && pop0 < base + 5; c++) begin
      @(negedge clk); #2;
    end
    reset_n = 1'b0;
    #1;
    vectors += 3;
    if (s0_ready !== 1'b0)  begin miscompares++; $display("[TB] FAIL midrst_ready got %b want 0", s0_ready); end
    if (p_char !== 8'h20)   begin miscompares++; $display("[TB] FAIL midrst_p_char got %h want 20", p_char); end
    if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_res_valid got %b want 0", res_valid); end
    q0.delete();
    q1.delete();
    sb.delete();
    expStat0 = 8'h00;
    expStat1 = 8'h00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    pushStr(0, "{\"k\":\"v\"}");
    pushStr(1, "{\"k\":\"v\"}");
    pushExp(0, 1, 0, 0);
    pushExp(1, 1, 0, 0);
    for (int c = 0; c < 200 && (sb.size() > 0 || q0.size() > 0 || q1.size() > 0); c++) begin
      @(negedge clk); #2;
      if (res_valid) begin
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("[TB] FAIL midrst_unexpected res_valid=1 want none"); end
        else begin
          exp = sb.pop_front();
          if ({res_src, res_num, res_gap, res_aborted} !== exp) begin
            miscompares++;
            $display("[TB] FAIL midrst_result got src=%0d num=%0d gap=%0d ab=%0d want src=%0d num=%0d gap=%0d ab=%0d",
                     res_src, res_num, res_gap, res_aborted, exp.src, exp.num, exp.gap, exp.aborted);
          end
        end
      end
    end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("[TB] FAIL midrst_timeout pending=%0d want 0", sb.size()); end
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] start json_parse_arbiter bench, MAX_OBJ_LEN=%0d stats=%0d", MAX_LEN, STATS_ON);
    test_reset();
    test_single();
    test_round_robin();
    test_gap();
    test_abort();
    test_empty_and_stats();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
